// File: rtl/race_draw_datapath.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : race_draw_datapath                                          |
// | Purpose  : Pixel generator for the race screen. Sweeps the background, |
// |            the car sprite or a car-sized erase box on request, feeds   |
// |            registered pixels to the VGA adapter and owns the car       |
// |            position register.                                         |
// | Ports    : clock/resetn    - clock, async active-low reset            |
// |            draw_bg/clear/draw_car - level requests (bg > clear > car)  |
// |            move_left/right/fwd    - single-cycle move pulses           |
// |            done_bg/done_erase/done_car - 4-phase completion flags      |
// |            bg_addr/bg_data, car_addr/car_data - ROM ports              |
// |            plot/vga_x/vga_y/vga_colour - registered VGA pixel write    |
// |            car_x/car_y     - current car position                     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module race_draw_datapath #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         CAR_W       = 16,
  parameter int         CAR_H       = 16,
  parameter int         X_START     = 72,
  parameter int         Y_START     = 100,
  parameter int         STEP_X      = 4,
  parameter int         STEP_Y      = 2,
  parameter logic [2:0] TRANSPARENT = 3'b000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        draw_bg,
  input  logic        draw_car,
  input  logic        clear,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        move_fwd,
  output logic        done_bg,
  output logic        done_car,
  output logic        done_erase,
  output logic [14:0] bg_addr,
  input  logic [2:0]  bg_data,
  output logic [7:0]  car_addr,
  input  logic [2:0]  car_data,
  output logic        plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic [7:0]  car_x,
  output logic [6:0]  car_y
);

  localparam logic [7:0] c_bg_last_i  = 8'(SCREEN_W - 1);
  localparam logic [6:0] c_bg_last_j  = 7'(SCREEN_H - 1);
  localparam logic [7:0] c_car_last_i = 8'(CAR_W - 1);
  localparam logic [6:0] c_car_last_j = 7'(CAR_H - 1);
  localparam logic [7:0] c_x_max      = 8'(SCREEN_W - CAR_W);
  localparam logic [6:0] c_y_wrap     = 7'(SCREEN_H - CAR_H);
  localparam logic [7:0] c_step_x     = 8'(STEP_X);
  localparam logic [6:0] c_step_y     = 7'(STEP_Y);
  localparam logic [7:0] c_x_start    = 8'(X_START);
  localparam logic [6:0] c_y_start    = 7'(Y_START);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SWEEP_BG    = 3'd1,
    S_SWEEP_ERASE = 3'd2,
    S_SWEEP_CAR   = 3'd3,
    S_FLUSH       = 3'd4,
    S_DONE        = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    K_BG    = 2'd0,
    K_ERASE = 2'd1,
    K_CAR   = 2'd2
  } kind_t;

  // Row-major 160-wide address without a multiplier: y*128 + y*32 + x.
  function automatic logic [14:0] f_addr(input logic [6:0] y, input logic [7:0] x);
    f_addr = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

  state_t     r_state;
  kind_t      r_kind;
  logic [7:0] r_i;
  logic [6:0] r_j;
  logic [7:0] r_cx;
  logic [6:0] r_cy;
  // Pipeline stage: coordinates of the pixel whose ROM address is on the bus.
  logic       r_pipe_valid;
  logic       r_pipe_car;
  logic [7:0] r_pipe_x;
  logic [6:0] r_pipe_y;

  logic       w_accept;
  logic       w_issue;
  logic       w_in_sweep;
  logic       w_end_row;
  logic       w_sweep_done;
  logic       w_req;
  kind_t      w_kind;
  logic [7:0] w_last_i;
  logic [6:0] w_last_j;
  logic [7:0] w_ni;
  logic [6:0] w_nj;
  logic [7:0] w_base_x;
  logic [6:0] w_base_y;
  logic [7:0] w_px;
  logic [6:0] w_py;

  always_comb begin
    w_accept   = (r_state == S_IDLE) && (draw_bg || clear || draw_car);
    w_in_sweep = (r_state == S_SWEEP_BG) || (r_state == S_SWEEP_ERASE) ||
                 (r_state == S_SWEEP_CAR);

    // In IDLE the kind comes from the requests; afterwards from the latch.
    w_kind = r_kind;
    if (r_state == S_IDLE) begin
      if (draw_bg)    w_kind = K_BG;
      else if (clear) w_kind = K_ERASE;
      else            w_kind = K_CAR;
    end

    w_last_i     = (w_kind == K_BG) ? c_bg_last_i : c_car_last_i;
    w_last_j     = (w_kind == K_BG) ? c_bg_last_j : c_car_last_j;
    w_end_row    = (r_i == w_last_i);
    w_sweep_done = w_in_sweep && w_end_row && (r_j == w_last_j);
    w_issue      = w_accept || (w_in_sweep && !w_sweep_done);

    // Next raster position to put on the address bus.
    if (w_accept) begin
      w_ni = 8'd0;
      w_nj = 7'd0;
    end else if (w_end_row) begin
      w_ni = 8'd0;
      w_nj = r_j + 7'd1;
    end else begin
      w_ni = r_i + 8'd1;
      w_nj = r_j;
    end

    // Car-relative sweeps use the live position on acceptance so the
    // snapshot and the first pixel agree even if a move lands that cycle.
    if (w_kind == K_BG) begin
      w_base_x = 8'd0;
      w_base_y = 7'd0;
    end else if (r_state == S_IDLE) begin
      w_base_x = car_x;
      w_base_y = car_y;
    end else begin
      w_base_x = r_cx;
      w_base_y = r_cy;
    end
    w_px = w_base_x + w_ni;
    w_py = w_base_y + w_nj;

    case (r_kind)
      K_BG:    w_req = draw_bg;
      K_ERASE: w_req = clear;
      default: w_req = draw_car;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_kind       <= K_BG;
      r_i          <= 8'd0;
      r_j          <= 7'd0;
      r_cx         <= 8'd0;
      r_cy         <= 7'd0;
      r_pipe_valid <= 1'b0;
      r_pipe_car   <= 1'b0;
      r_pipe_x     <= 8'd0;
      r_pipe_y     <= 7'd0;
      bg_addr      <= 15'd0;
      car_addr     <= 8'd0;
      plot         <= 1'b0;
      vga_x        <= 8'd0;
      vga_y        <= 7'd0;
      vga_colour   <= 3'd0;
      done_bg      <= 1'b0;
      done_car     <= 1'b0;
      done_erase   <= 1'b0;
      car_x        <= c_x_start;
      car_y        <= c_y_start;
    end else begin
      // Output stage: ROM data for the piped pixel is valid now.
      plot <= 1'b0;
      if (r_pipe_valid) begin
        vga_x      <= r_pipe_x;
        vga_y      <= r_pipe_y;
        vga_colour <= r_pipe_car ? car_data : bg_data;
        plot       <= !r_pipe_car || (car_data != TRANSPARENT);
      end

      r_pipe_valid <= 1'b0;
      if (w_issue) begin
        r_i          <= w_ni;
        r_j          <= w_nj;
        r_pipe_valid <= 1'b1;
        r_pipe_car   <= (w_kind == K_CAR);
        r_pipe_x     <= w_px;
        r_pipe_y     <= w_py;
        if (w_kind == K_CAR) car_addr <= {w_nj[3:0], w_ni[3:0]};
        else                 bg_addr  <= f_addr(w_py, w_px);
      end

      case (r_state)
        S_IDLE: begin
          if (move_left && !move_right)
            car_x <= (car_x < c_step_x) ? 8'd0 : car_x - c_step_x;
          else if (move_right && !move_left)
            car_x <= (car_x > c_x_max - c_step_x) ? c_x_max : car_x + c_step_x;
          if (move_fwd)
            car_y <= (car_y < c_step_y) ? c_y_wrap : car_y - c_step_y;

          if (w_accept) begin
            r_kind <= w_kind;
            r_cx   <= car_x;
            r_cy   <= car_y;
            case (w_kind)
              K_BG:    r_state <= S_SWEEP_BG;
              K_ERASE: r_state <= S_SWEEP_ERASE;
              default: r_state <= S_SWEEP_CAR;
            endcase
          end
        end
        S_SWEEP_BG, S_SWEEP_ERASE, S_SWEEP_CAR: begin
          if (w_sweep_done) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          r_state <= S_DONE;
          case (r_kind)
            K_BG:    done_bg    <= 1'b1;
            K_ERASE: done_erase <= 1'b1;
            default: done_car   <= 1'b1;
          endcase
        end
        S_DONE: begin
          if (!w_req) begin
            done_bg    <= 1'b0;
            done_erase <= 1'b0;
            done_car   <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
